// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller port bundle
interface pipeline_hazard_ctrl_if;
    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        perf_clr;
    logic        stall_fetch;
    logic        flush_fetch;
    logic        stall_dec;
    logic        nop_dec;
    logic [15:0] lost_cycles;
    logic        flushing;

    modport master (
        output dec_opcode, dec_rs1, dec_rs2, ex_opcode, ex_rd,
        output branch_taken, mem_req, mem_ready, perf_clr,
        input  stall_fetch, flush_fetch, stall_dec, nop_dec, lost_cycles, flushing
    );

    modport slave (
        input  dec_opcode, dec_rs1, dec_rs2, ex_opcode, ex_rd,
        input  branch_taken, mem_req, mem_ready, perf_clr,
        output stall_fetch, flush_fetch, stall_dec, nop_dec, lost_cycles, flushing
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, redirect flush and memory freeze controller
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [6:0]  LOAD_OPCODE  = 7'b0000011
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [3:0]  fcnt;
    logic [15:0] lost_q;
    logic        frz;
    logic        redirect;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        load_use;

    always_comb begin
        frz      = hz.mem_req & ~hz.mem_ready;
        redirect = hz.branch_taken & ~frz;
        uses_rs1 = !(hz.dec_opcode == 7'b0110111 || hz.dec_opcode == 7'b0010111 ||
                     hz.dec_opcode == 7'b1101111);
        uses_rs2 = (hz.dec_opcode == 7'b0110011 || hz.dec_opcode == 7'b0100011 ||
                    hz.dec_opcode == 7'b1100011);
        load_use = (state == RUN) && !redirect && !frz &&
                   (hz.ex_opcode == LOAD_OPCODE) && (hz.ex_rd != 5'd0) &&
                   (((hz.ex_rd == hz.dec_rs1) && uses_rs1) ||
                    ((hz.ex_rd == hz.dec_rs2) && uses_rs2));
    end

    // Priority: reset fill, memory freeze, redirect, flush train, load-use bubble.
    always_comb begin
        hz.stall_fetch = 1'b0;
        hz.flush_fetch = 1'b0;
        hz.stall_dec   = 1'b0;
        hz.nop_dec     = 1'b0;
        if (rst) begin
            hz.stall_fetch = 1'b1;
            hz.flush_fetch = 1'b1;
            hz.nop_dec     = 1'b1;
        end else if (frz) begin
            hz.stall_fetch = 1'b1;
            hz.stall_dec   = 1'b1;
        end else if (redirect || state == FLUSH) begin
            hz.flush_fetch = 1'b1;
            hz.nop_dec     = 1'b1;
        end else if (load_use) begin
            hz.stall_fetch = 1'b1;
            hz.nop_dec     = 1'b1;
        end
    end

    assign hz.flushing    = (state == FLUSH) && !rst;
    assign hz.lost_cycles = lost_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            fcnt   <= 4'd0;
            lost_q <= 16'd0;
        end else begin
            if (!frz) begin
                if (redirect) begin
                    if (FLUSH_CYCLES > 1) begin
                        state <= FLUSH;
                        fcnt  <= FCNT_LOAD;
                    end else begin
                        state <= RUN;
                        fcnt  <= 4'd0;
                    end
                end else if (state == FLUSH) begin
                    fcnt <= fcnt - 4'd1;
                    if (fcnt <= 4'd1) begin
                        state <= RUN;
                    end
                end
            end
            if (hz.perf_clr) begin
                lost_q <= 16'd0;
            end else if ((hz.stall_fetch || hz.nop_dec) && lost_q != 16'hFFFF) begin
                lost_q <= lost_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // Output vector order: stall_fetch, flush_fetch, stall_dec, nop_dec, flushing
    localparam logic [4:0] O_IDLE   = 5'b00000;
    localparam logic [4:0] O_RST    = 5'b11010;
    localparam logic [4:0] O_LU     = 5'b10010;
    localparam logic [4:0] O_REDIR  = 5'b01010;
    localparam logic [4:0] O_FLUSH  = 5'b01011;
    localparam logic [4:0] O_FRZ    = 5'b10100;
    localparam logic [4:0] O_FRZ_FL = 5'b10101;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_OPCODE(7'b0000011)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {hz.stall_fetch, hz.flush_fetch, hz.stall_dec, hz.nop_dec, hz.flushing};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.dec_opcode   = OP_ALUI;
        hz.dec_rs1      = 5'd0;
        hz.dec_rs2      = 5'd0;
        hz.ex_opcode    = OP_ALUI;
        hz.ex_rd        = 5'd0;
        hz.branch_taken = 1'b0;
        hz.mem_req      = 1'b0;
        hz.mem_ready    = 1'b0;
        hz.perf_clr     = 1'b0;
    endtask

    task automatic clear_perf();
        hz.perf_clr = 1'b1;
        tick();
        hz.perf_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (outs() !== O_RST) begin
            errors++;
            $display("FAIL reset_outs got %b want %b", outs(), O_RST);
        end
        tick();
        tick();
        checks++;
        if (hz.lost_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_lost got %h want 0000", hz.lost_cycles);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== O_IDLE) begin
            errors++;
            $display("FAIL idle_outs got %b want %b", outs(), O_IDLE);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [6:0] dop [4];
        logic [4:0] rs1 [4];
        logic [4:0] rs2 [4];
        clear_perf();
        hz.ex_opcode  = OP_LOAD;
        hz.ex_rd      = 5'd5;
        hz.dec_opcode = OP_ALU;
        hz.dec_rs1    = 5'd1;
        hz.dec_rs2    = 5'd5;
        #1;
        checks++;
        if (outs() !== O_LU) begin
            errors++;
            $display("FAIL load_use_rs2 got %b want %b", outs(), O_LU);
        end
        tick();
        hz.ex_opcode = OP_ALUI;
        hz.ex_rd     = 5'd0;
        #1;
        checks++;
        if (outs() !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_after got %b want %b", outs(), O_IDLE);
        end
        checks++;
        if (hz.lost_cycles !== 16'd1) begin
            errors++;
            $display("FAIL load_use_lost got %h want 0001", hz.lost_cycles);
        end
        // Hazards that must stall: I-type via rs1, store via rs2
        dop[0] = OP_ALUI;  rs1[0] = 5'd5; rs2[0] = 5'd0;
        dop[1] = OP_STORE; rs1[1] = 5'd2; rs2[1] = 5'd5;
        // Hazards that must not: LUI ignores rs1, I-type ignores rs2
        dop[2] = OP_LUI;   rs1[2] = 5'd5; rs2[2] = 5'd0;
        dop[3] = OP_ALUI;  rs1[3] = 5'd3; rs2[3] = 5'd5;
        hz.ex_opcode = OP_LOAD;
        hz.ex_rd     = 5'd5;
        for (int i = 0; i < 4; i++) begin
            hz.dec_opcode = dop[i];
            hz.dec_rs1    = rs1[i];
            hz.dec_rs2    = rs2[i];
            #1;
            checks++;
            if (outs() !== ((i < 2) ? O_LU : O_IDLE)) begin
                errors++;
                $display("FAIL load_use_vec%0d got %b want %b", i, outs(),
                         (i < 2) ? O_LU : O_IDLE);
            end
        end
        hz.ex_rd      = 5'd0;
        hz.dec_opcode = OP_ALU;
        hz.dec_rs1    = 5'd0;
        hz.dec_rs2    = 5'd0;
        #1;
        checks++;
        if (outs() !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_x0 got %b want %b", outs(), O_IDLE);
        end
        hz.ex_opcode = OP_ALUI;
        hz.ex_rd     = 5'd5;
        hz.dec_rs1   = 5'd5;
        #1;
        checks++;
        if (outs() !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_notload got %b want %b", outs(), O_IDLE);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_redirect();
        logic [4:0] exp [4];
        exp[0] = O_REDIR; exp[1] = O_FLUSH; exp[2] = O_FLUSH; exp[3] = O_IDLE;
        clear_perf();
        hz.branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL redirect_c%0d got %b want %b", i, outs(), exp[i]);
            end
            tick();
            hz.branch_taken = 1'b0;
        end
        checks++;
        if (hz.lost_cycles !== 16'd3) begin
            errors++;
            $display("FAIL redirect_lost got %h want 0003", hz.lost_cycles);
        end
    endtask

    task automatic test_freeze_in_flush();
        logic [4:0] exp [8];
        exp[0] = O_REDIR;
        for (int i = 1; i < 5; i++) exp[i] = O_FRZ_FL;
        exp[5] = O_FLUSH; exp[6] = O_FLUSH; exp[7] = O_IDLE;
        clear_perf();
        for (int i = 0; i < 8; i++) begin
            hz.branch_taken = (i == 0);
            hz.mem_req      = (i >= 1 && i <= 4);
            hz.mem_ready    = 1'b0;
            #1;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL freeze_flush_c%0d got %b want %b", i, outs(), exp[i]);
            end
            tick();
        end
        checks++;
        if (hz.lost_cycles !== 16'd7) begin
            errors++;
            $display("FAIL freeze_flush_lost got %h want 0007", hz.lost_cycles);
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        hz.mem_req   = 1'b1;
        hz.mem_ready = 1'b1;
        #1;
        checks++;
        if (outs() !== O_IDLE) begin
            errors++;
            $display("FAIL mem_ready_nofreeze got %b want %b", outs(), O_IDLE);
        end
        // Freeze masks a redirect; it is taken on the first unfrozen cycle
        hz.mem_ready    = 1'b0;
        hz.branch_taken = 1'b1;
        #1;
        checks++;
        if (outs() !== O_FRZ) begin
            errors++;
            $display("FAIL freeze_vs_branch got %b want %b", outs(), O_FRZ);
        end
        tick();
        hz.mem_req = 1'b0;
        #1;
        checks++;
        if (outs() !== O_REDIR) begin
            errors++;
            $display("FAIL branch_after_freeze got %b want %b", outs(), O_REDIR);
        end
        tick();
        hz.branch_taken = 1'b0;
        repeat (2) tick();
        // Freeze masks a load-use, which reappears afterwards
        hz.ex_opcode  = OP_LOAD;
        hz.ex_rd      = 5'd7;
        hz.dec_opcode = OP_ALU;
        hz.dec_rs1    = 5'd7;
        hz.mem_req    = 1'b1;
        #1;
        checks++;
        if (outs() !== O_FRZ) begin
            errors++;
            $display("FAIL freeze_vs_load_use got %b want %b", outs(), O_FRZ);
        end
        tick();
        hz.mem_req = 1'b0;
        #1;
        checks++;
        if (outs() !== O_LU) begin
            errors++;
            $display("FAIL load_use_after_freeze got %b want %b", outs(), O_LU);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp [5];
        exp[0] = O_REDIR; exp[1] = O_FLUSH; exp[2] = O_FLUSH; exp[3] = O_FLUSH; exp[4] = O_IDLE;
        clear_perf();
        for (int i = 0; i < 5; i++) begin
            hz.branch_taken = (i < 2);
            #1;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL back_to_back_c%0d got %b want %b", i, outs(), exp[i]);
            end
            tick();
        end
        checks++;
        if (hz.lost_cycles !== 16'd4) begin
            errors++;
            $display("FAIL back_to_back_lost got %h want 0004", hz.lost_cycles);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        clear_perf();
        hz.branch_taken = 1'b1;
        tick();
        hz.branch_taken = 1'b0;
        #1;
        checks++;
        if (hz.lost_cycles !== 16'd1 || outs() !== O_FLUSH) begin
            errors++;
            $display("FAIL pre_reset got %h/%b want 0001/%b", hz.lost_cycles, outs(), O_FLUSH);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs() !== O_RST || hz.lost_cycles !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got %b/%h want %b/0000", outs(), hz.lost_cycles, O_RST);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (outs() !== O_IDLE) begin
            errors++;
            $display("FAIL post_reset got %b want %b", outs(), O_IDLE);
        end
        tick();
        checks++;
        if (outs() !== O_IDLE || hz.lost_cycles !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_cycle got %b/%h want %b/0000", outs(), hz.lost_cycles, O_IDLE);
        end
    endtask

    task automatic test_saturation();
        hz.mem_req   = 1'b1;
        hz.mem_ready = 1'b0;
        hz.perf_clr  = 1'b1;
        tick();
        hz.perf_clr = 1'b0;
        checks++;
        if (hz.lost_cycles !== 16'd0) begin
            errors++;
            $display("FAIL clr_priority got %h want 0000", hz.lost_cycles);
        end
        repeat (65534) tick();
        checks++;
        if (hz.lost_cycles !== 16'hFFFE) begin
            errors++;
            $display("FAIL preload got %h want fffe", hz.lost_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (hz.lost_cycles !== 16'hFFFF) begin
                errors++;
                $display("FAIL saturate_c%0d got %h want ffff", i, hz.lost_cycles);
            end
        end
        hz.mem_req  = 1'b0;
        hz.perf_clr = 1'b1;
        tick();
        hz.perf_clr = 1'b0;
        checks++;
        if (hz.lost_cycles !== 16'd0) begin
            errors++;
            $display("FAIL perf_clr got %h want 0000", hz.lost_cycles);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_redirect();
        test_freeze_in_flush();
        test_priority();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
